shift_seq_ctrl: RTL

Sequencing controller for the team's 8-bit serial-in shift register (inputs d/en/dir, parallel output). It accepts a command over a valid/ready handshake and shifts a programmable number of bits into the register in the requested direction. It then captures the register's parallel output and returns it on a response handshake. It sits between a bus-side command source and one shift register instance.

---
 rtl/shift_seq_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// Shifts a command's low len bits into an external serial-in shift register, then returns its parallel value.
// Accept to response: L+2 cycles; the response is held until rsp_ready, and no command is taken outside IDLE.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             sr_d,
  output logic             sr_en,
  output logic             sr_dir,
  input  logic [WIDTH-1:0] sr_q,
  input  logic             abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [CNT_W-1:0] rsp_count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, RESP} state_t;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sr_en_q, sr_en_d;
  logic             sr_d_q, sr_d_d;
  logic             sr_dir_q, sr_dir_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0] rsp_count_q, rsp_count_d;

  logic [CNT_W-1:0] cmd_len_eff;
  logic             accept;
  logic             last_shift;

  // Bit k (1-based) of the field: MSB first when shifting left, LSB first when shifting right.
  function automatic logic pick_bit(input logic [WIDTH-1:0] data, input logic dir,
                                    input logic [CNT_W-1:0] len, input logic [CNT_W-1:0] k);
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] sh;
    idx = dir ? (k - 1'b1) : (len - k);
    sh  = data >> idx;
    return sh[0];
  endfunction

  assign cmd_len_eff = ((cmd_len == '0) || (cmd_len > WIDTH_C)) ? WIDTH_C : cmd_len;
  assign accept      = cmd_valid && (state_q == IDLE);
  // cnt_q is the index of the bit being shifted this cycle, so it is also the shift count so far.
  assign last_shift  = (cnt_q == len_q) || abort;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
  end

  always_comb begin
    dir_d       = dir_q;
    data_d      = data_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sr_en_d     = 1'b0;
    sr_d_d      = 1'b0;
    sr_dir_d    = sr_dir_q;
    rsp_data_d  = rsp_data_q;
    rsp_count_d = rsp_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dir_d    = cmd_dir;
          data_d   = cmd_data;
          len_d    = cmd_len_eff;
          sr_dir_d = cmd_dir;
          cnt_d    = CNT_W'(1);
          sr_en_d  = 1'b1;
          sr_d_d   = pick_bit(cmd_data, cmd_dir, cmd_len_eff, CNT_W'(1));
        end
      end
      SHIFT: begin
        if (last_shift) begin
          rsp_count_d = cnt_q;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          sr_en_d = 1'b1;
          sr_d_d  = pick_bit(data_q, dir_q, len_q, cnt_q + 1'b1);
        end
      end
      CAPTURE: rsp_data_d = sr_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dir_q       <= 1'b0;
      data_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      sr_en_q     <= 1'b0;
      sr_d_q      <= 1'b0;
      sr_dir_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_count_q <= '0;
    end else begin
      dir_q       <= dir_d;
      data_q      <= data_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sr_en_q     <= sr_en_d;
      sr_d_q      <= sr_d_d;
      sr_dir_q    <= sr_dir_d;
      rsp_data_q  <= rsp_data_d;
      rsp_count_q <= rsp_count_d;
    end
  end

  assign sr_en     = sr_en_q;
  assign sr_d      = sr_d_q;
  assign sr_dir    = sr_dir_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_count = rsp_count_q;

endmodule
